// File: rtl/bf8_bus_pkg.sv
// Shared definitions for the BrainForge8 bus arbiter: state encoding, width helpers,
// and fixed master indices.
package bf8_bus_pkg;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StWaitBa = 2'd1,
    StOwn    = 2'd2,
    StTurn   = 2'd3
  } bus_state_e;

  localparam int unsigned MASTER_CORE = 0;

  // Ceiling log2; clog2(1) = 0.
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    while ((32'd1 << r) < n) r++;
    return r;
  endfunction

  // Index width that never collapses to zero bits.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bus_arb_pick.sv
// Combinational winner picker: scans req_i starting at base_i (wrapping) and returns
// the first requesting index. With base_i = 0 this is plain lowest-index-wins.
module bus_arb_pick
  import bf8_bus_pkg::*;
#(
  parameter int unsigned NUM_MASTERS = 4,
  localparam int unsigned IdxW = idx_width(NUM_MASTERS)
) (
  input  logic [NUM_MASTERS-1:0] req_i,
  input  logic [IdxW-1:0]        base_i,
  output logic [IdxW-1:0]        idx_o,
  output logic                   valid_o
);

  int unsigned cand;
  logic        found;

  // Rotating first-set search from the base index.
  always_comb begin
    idx_o   = '0;
    valid_o = |req_i;
    found   = 1'b0;
    cand    = 0;
    for (int unsigned k = 0; k < NUM_MASTERS; k++) begin
      cand = (32'(base_i) + k) % NUM_MASTERS;
      if (!found && req_i[cand[IdxW-1:0]]) begin
        idx_o = cand[IdxW-1:0];
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/bus_arbiter.sv
// bus_arbiter: arbitrates NUM_MASTERS internal masters onto the external bus using the
// BR/BA handshake, with a hold limit, external preemption and a turnaround cycle.
// Define BUS_ARB_RR_EN for round-robin selection; default is fixed priority (index 0 wins).
module bus_arbiter
  import bf8_bus_pkg::*;
#(
  parameter int unsigned NUM_MASTERS = 4,
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned ADDR_W      = 16,
  parameter int unsigned MAX_HOLD    = 16,
  localparam int unsigned IdxW = idx_width(NUM_MASTERS)
) (
  input  logic                          CLK,
  input  logic                          RST,
  input  logic [NUM_MASTERS-1:0]        REQ,
  output logic [NUM_MASTERS-1:0]        GNT,
  input  logic [NUM_MASTERS*DATA_W-1:0] M_DATA,
  input  logic [NUM_MASTERS*ADDR_W-1:0] M_ADDR,
  input  logic [NUM_MASTERS-1:0]        M_RW,
  input  logic [NUM_MASTERS-1:0]        M_IF,
  output logic [DATA_W-1:0]             D_OUT,
  output logic                          D_OE,
  output logic [ADDR_W-1:0]             A,
  output logic                          CTL_OE,
  output logic                          RW,
  output logic                          IF,
  output logic                          DT,
  output logic                          BR,
  input  logic                          BA,
  output logic [IdxW-1:0]               OWNER
);

  // Counter tops out at the last allowed cycle; saturating there keeps a lone owner in place.
  localparam int unsigned HoldLast = (MAX_HOLD == 0) ? 0 : MAX_HOLD - 1;
  localparam int unsigned CntW     = idx_width(HoldLast + 1);

  bus_state_e              state_q, state_d;
  logic [IdxW-1:0]         owner_q, owner_d;
  logic [CntW-1:0]         cnt_q, cnt_d;
  logic [NUM_MASTERS-1:0]  gnt_q, gnt_d;
  logic                    br_q, br_d, d_oe_q, d_oe_d, ctl_oe_q, ctl_oe_d;
  logic                    rw_q, rw_d, if_q, if_d, dt_q, dt_d;
  logic [DATA_W-1:0]       d_out_q, d_out_d;
  logic [ADDR_W-1:0]       a_q, a_d;
  logic [NUM_MASTERS-1:0]  others;
  logic [IdxW-1:0]         pick_base, pick_idx;
  logic                    pick_valid;

  logic [DATA_W-1:0] data_arr [NUM_MASTERS];
  logic [ADDR_W-1:0] addr_arr [NUM_MASTERS];

  for (genvar g = 0; g < NUM_MASTERS; g++) begin : g_unpack
    assign data_arr[g] = M_DATA[g*DATA_W +: DATA_W];
    assign addr_arr[g] = M_ADDR[g*ADDR_W +: ADDR_W];
  end

`ifdef BUS_ARB_RR_EN
  logic [IdxW-1:0] rr_q, rr_d;
  assign pick_base = rr_q;
`else
  assign pick_base = '0;
`endif

  bus_arb_pick #(
    .NUM_MASTERS(NUM_MASTERS)
  ) u_pick (
    .req_i  (REQ),
    .base_i (pick_base),
    .idx_o  (pick_idx),
    .valid_o(pick_valid)
  );

  // Next state, owner, hold counter and round-robin pointer.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    cnt_d   = cnt_q;
`ifdef BUS_ARB_RR_EN
    rr_d    = rr_q;
`endif
    others          = REQ;
    others[owner_q] = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (|REQ) state_d = StWaitBa;
      end
      StWaitBa: begin
        if (!pick_valid) begin
          state_d = StIdle;
        end else if (BA) begin
          state_d = StOwn;
          owner_d = pick_idx;
          cnt_d   = '0;
`ifdef BUS_ARB_RR_EN
          rr_d    = (pick_idx == IdxW'(NUM_MASTERS - 1)) ? '0 : pick_idx + 1'b1;
`endif
        end
      end
      StOwn: begin
        // Exit priority: BA loss, owner release, hold limit (only when someone else waits).
        if (!BA || !REQ[owner_q] ||
            ((MAX_HOLD != 0) && (cnt_q == CntW'(HoldLast)) && (|others))) begin
          state_d = StTurn;
          cnt_d   = '0;
        end else if (cnt_q != CntW'(HoldLast)) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StTurn: begin
        state_d = (|REQ) ? StWaitBa : StIdle;
        cnt_d   = '0;
      end
      default: state_d = StIdle;
    endcase
  end

  // Registered bus outputs follow the state being entered; the owner's M_* are captured now.
  always_comb begin
    gnt_d    = '0;
    br_d     = 1'b0;
    d_oe_d   = 1'b0;
    ctl_oe_d = 1'b0;
    d_out_d  = '0;
    a_d      = '0;
    rw_d     = 1'b1;
    if_d     = 1'b0;
    dt_d     = 1'b0;
    unique case (state_d)
      StWaitBa: br_d = 1'b1;
      StOwn: begin
        br_d           = 1'b1;
        gnt_d[owner_d] = 1'b1;
        ctl_oe_d       = 1'b1;
        d_oe_d         = ~M_RW[owner_d];
        d_out_d        = data_arr[owner_d];
        a_d            = addr_arr[owner_d];
        rw_d           = M_RW[owner_d];
        if_d           = M_IF[owner_d];
        dt_d           = (owner_d != IdxW'(MASTER_CORE));
      end
      StTurn:  br_d = |REQ;
      default: ;
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q  <= StIdle;
      owner_q  <= '0;
      cnt_q    <= '0;
      gnt_q    <= '0;
      br_q     <= 1'b0;
      d_oe_q   <= 1'b0;
      ctl_oe_q <= 1'b0;
      d_out_q  <= '0;
      a_q      <= '0;
      rw_q     <= 1'b1;
      if_q     <= 1'b0;
      dt_q     <= 1'b0;
`ifdef BUS_ARB_RR_EN
      rr_q     <= '0;
`endif
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      cnt_q    <= cnt_d;
      gnt_q    <= gnt_d;
      br_q     <= br_d;
      d_oe_q   <= d_oe_d;
      ctl_oe_q <= ctl_oe_d;
      d_out_q  <= d_out_d;
      a_q      <= a_d;
      rw_q     <= rw_d;
      if_q     <= if_d;
      dt_q     <= dt_d;
`ifdef BUS_ARB_RR_EN
      rr_q     <= rr_d;
`endif
    end
  end

  assign GNT    = gnt_q;
  assign BR     = br_q;
  assign D_OE   = d_oe_q;
  assign CTL_OE = ctl_oe_q;
  assign D_OUT  = d_out_q;
  assign A      = a_q;
  assign RW     = rw_q;
  assign IF     = if_q;
  assign DT     = dt_q;
  assign OWNER  = owner_q;

endmodule

// File: doc/bus_arbiter.md
# bus_arbiter

Parametrised successor to the two-driver BrainForge8 bus unit. Arbitrates NUM_MASTERS internal masters (index 0 = core, 1..N-1 = DMA channels or other agents) onto the single external bus, and negotiates the bus with the outside world through the BR/BA handshake. Adds a hold-limit for fairness, external preemption, a turnaround cycle, and optional round-robin selection. Sits between the core/DMA instances and the pad-level tri-state drivers in the top-level package.

## Interface
Parameters:
- NUM_MASTERS, 4, number of internal masters (2..8)
- DATA_W, 8, data bus width
- ADDR_W, 16, address bus width
- MAX_HOLD, 16, max consecutive OWN cycles before forced release when another master requests; 0 = unlimited

Ports:
- CLK  in  1  system clock
- RST  in  1  reset, synchronous, active-low
- REQ  in  NUM_MASTERS  per-master bus request
- GNT  out  NUM_MASTERS  per-master grant, one-hot or zero
- M_DATA  in  NUM_MASTERS*DATA_W  per-master write data, master i at [i*DATA_W +: DATA_W]
- M_ADDR  in  NUM_MASTERS*ADDR_W  per-master address
- M_RW  in  NUM_MASTERS  per-master read(1)/write(0)
- M_IF  in  NUM_MASTERS  per-master instruction-fetch flag
- D_OUT  out  DATA_W  data to pads
- D_OE  out  1  data output enable (1 only when owner writes)
- A  out  ADDR_W  address to pads
- CTL_OE  out  1  enable for A, RW, IF, DT pads
- RW  out  1  bus RW
- IF  out  1  bus IF
- DT  out  1  DMA transfer: owner index != 0
- BR  out  1  external bus request
- BA  in  1  external bus available
- OWNER  out  clog2(NUM_MASTERS)  current owner index (debug/DMA status)

## Operation
- States: IDLE, WAIT_BA, OWN, TURN.
- IDLE: BR=0, GNT=0, OE=0. Any REQ -> WAIT_BA.
- WAIT_BA: BR=1. No REQ -> IDLE. BA=1 -> pick winner from current REQ, -> OWN.
- OWN: BR=1, GNT[owner]=1, CTL_OE=1, D_OE=~M_RW[owner]; A/RW/IF/D_OUT mux from owner. Hold counter increments each OWN cycle.
  - BA=0 -> TURN (external preemption).
  - REQ[owner]=0 -> TURN.
  - MAX_HOLD!=0, counter = MAX_HOLD-1, another REQ set -> TURN (forced); owner keeps REQ and re-competes.
  - Priority of exits: BA=0, then owner release, then hold limit.
- TURN: exactly one cycle, GNT=0, all OE=0, BR=|REQ. -> WAIT_BA if |REQ else IDLE. Hold counter cleared.
- Winner selection: fixed priority, lowest index wins (see Configuration for round-robin).
- Single requester never forced out by hold limit.
- REQ from non-owners during OWN has no effect until TURN.

## Timing
- All outputs registered. Reset values: GNT=0, BR=0, D_OE=0, CTL_OE=0, D_OUT=0, A=0, RW=1, IF=0, DT=0, OWNER=0, state IDLE, counter 0, RR pointer 0.
- REQ rises at edge t (IDLE, BA=1 held): BR=1 at t+1; GNT and bus drive at t+2.
- Owner drops REQ at t: GNT=0 and OE=0 at t+1 (TURN); next grant earliest t+3.
- BA falls at t: GNT=0, OE=0 at t+1; no bus drive after BA loss beyond one cycle.
- Address/data mux: owner's M_* sampled at t, presented at t+1 (one-cycle pipeline); masters hold M_* stable while GNT=1.
- RST low at any edge: all state and outputs return to reset values next edge, mid-transfer included; GNT drops same edge.

## Configuration
- BUS_ARB_RR_EN defined: round-robin; search starts at (last_owner+1) mod NUM_MASTERS, pointer updated on each entry to OWN.
- Undefined: fixed priority, index 0 highest; no pointer register synthesised.

## Structure
- Shared package bf8_bus_pkg: state encoding localparams, clog2 function, master index constants (MASTER_CORE=0).
- Sub-module bus_arb_pick: combinational one-hot picker, inputs REQ and base index, output winner index + valid; used once.
- Counter, FSM, output mux in bus_arbiter.

## Test plan
- Reset: drive RST=0 3 cycles with REQ=4'b1111, BA=1 -> all outputs at reset values, RW=1, BR=0.
- Single request: REQ=4'b0010, BA=1 -> BR=1 at +1, GNT=4'b0010, DT=1, OWNER=1 at +2; drop REQ -> one TURN cycle then IDLE, BR=0.
- Fixed priority: REQ=4'b1010 -> GNT=4'b0010; with BUS_ARB_RR_EN, after master 1 releases and both re-request -> GNT=4'b1000.
- Hold limit: MAX_HOLD=4, REQ=4'b0011 held -> master 0 owns exactly 4 cycles, TURN, then master 1 (RR) or master 0 again (fixed); REQ=4'b0001 alone -> never forced out.
- Preemption: BA=0 during OWN -> GNT=0, D_OE=0, CTL_OE=0 next cycle; BA=1 again -> regrant after WAIT_BA.
- Write path: master 2 owns, M_RW=0, M_ADDR=16'h1234, M_DATA=8'hA5 -> A=16'h1234, D_OUT=8'hA5, D_OE=1, RW=0, DT=1 one cycle later.
